// File: rtl/seg_scan_multi.sv
// Multiplexed 7/8-segment display scanner: one shared segment bus, one-hot digit select,
// prescaled slots with leading blanking, skip of disabled digits, and per-frame snapshot of the words.
module seg_scan_multi #(
  parameter int NUM_DIGITS     = 6,
  parameter int SEG_W          = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYC      = 1000,
  parameter int SEL_ACTIVE_LOW = 1,
  parameter int SEG_OFF_LEVEL  = 1
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic [NUM_DIGITS*SEG_W-1:0]                           seg_data_in,
  input  logic [NUM_DIGITS-1:0]                                 digit_en,
  output logic [NUM_DIGITS-1:0]                                 seg_sel,
  output logic [SEG_W-1:0]                                      seg_data,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] cur_digit,
  output logic                                                  frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_ON    = 2'd2;
  localparam logic [1:0] S_START = (BLANK_CYC == 0) ? S_ON : S_BLANK;

  localparam logic [CNT_W-1:0] LP_SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] LP_BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [NUM_DIGITS-1:0] LP_SEL_OFF =
    (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [SEG_W-1:0] LP_SEG_OFF = {SEG_W{(SEG_OFF_LEVEL != 0)}};

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_ft;
  logic [SEG_W-1:0] r_shadow [NUM_DIGITS];

  logic             w_any_en;
  logic             w_new_frame;
  logic [IDX_W-1:0] w_first_idx;
  logic [IDX_W-1:0] w_next_idx;
  int               w_j;

  function automatic logic [NUM_DIGITS-1:0] f_sel(input logic [IDX_W-1:0] idx);
    logic [NUM_DIGITS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return (SEL_ACTIVE_LOW != 0) ? ~oh : oh;
  endfunction

  // Lowest enabled digit, and the circular successor of r_idx (which may be r_idx itself).
  always_comb begin
    w_any_en    = |digit_en;
    w_first_idx = '0;
    w_next_idx  = r_idx;
    w_j         = 0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (digit_en[i]) w_first_idx = IDX_W'(i);
    end
    for (int k = NUM_DIGITS; k >= 1; k--) begin
      w_j = (int'(r_idx) + k) % NUM_DIGITS;
      if (digit_en[w_j]) w_next_idx = IDX_W'(w_j);
    end
    w_new_frame = (w_next_idx <= r_idx);
  end

  // Slot sequencer: state, slot counter, owning digit, frame snapshot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_ft    <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) r_shadow[i] <= LP_SEG_OFF;
    end else begin
      r_ft <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_en) begin
            r_idx   <= w_first_idx;
            r_cnt   <= '0;
            r_ft    <= 1'b1;
            r_state <= S_START;
            for (int i = 0; i < NUM_DIGITS; i++) r_shadow[i] <= seg_data_in[i*SEG_W +: SEG_W];
          end
        end
        S_BLANK: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LP_BLANK_LAST) r_state <= S_ON;
        end
        default: begin
          if (r_cnt == LP_SLOT_LAST) begin
            r_cnt <= '0;
            if (!w_any_en) begin
              r_state <= S_IDLE;
            end else begin
              r_idx   <= w_next_idx;
              r_state <= S_START;
              if (w_new_frame) begin
                r_ft <= 1'b1;
                for (int i = 0; i < NUM_DIGITS; i++) r_shadow[i] <= seg_data_in[i*SEG_W +: SEG_W];
              end
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Pin stage: registered from the sequencer, one clock behind it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_sel   <= LP_SEL_OFF;
      seg_data  <= LP_SEG_OFF;
      cur_digit <= '0;
    end else begin
      seg_sel   <= (r_state == S_ON) ? f_sel(r_idx) : LP_SEL_OFF;
      seg_data  <= (r_state == S_ON) ? r_shadow[r_idx] : LP_SEG_OFF;
      cur_digit <= r_idx;
    end
  end

  assign frame_tick = r_ft;

endmodule
